sccb_target: RTL
================

// Module: sccb_target
// PURPOSE
//  SCCB target (camera-side responder) for the 2-wire SCCB bus. Oversamples SIO_C/SIO_D on XCLK.
//  Decodes 3-phase write and 2-phase write + 2-phase read transactions into an internal register file.
//  Drives read data back to the initiator.
//  Used as a bus-functional camera model in simulation and as a loopback target on FPGA.
// PARAMETERS
//  DEVICE_ID  8'h42  write ID; bits [7:1] are matched, bit 0 is R/W (1=read)
//  NUM_REGS   256    register-file depth; sub-address modulo NUM_REGS
//  RESET_VAL  8'h00  reset value of every register-file entry
// PORTS
//  XCLK        in   1  system clock; must be >= 8x SIO_C frequency
//  RST         in   1  synchronous reset, active-high
//  SIO_C       in   1  SCCB clock from initiator
//  SIO_D_in    in   1  SCCB data as seen on the pad
//  SIO_D_out   out  1  data driven by target
//  SIO_D_oe    out  1  1 = target drives SIO_D_out onto the pad; 0 = high-Z
//  wr_strobe   out  1  one-XCLK pulse when a register is written
//  wr_addr     out  8  register address of the current or last write
//  wr_data     out  8  data of the current or last write
//  sub_addr    out  8  currently latched sub-address pointer
//  busy        out  1  1 from START until STOP
//  id_err      out  1  sticky; set on an ID mismatch, cleared by RST
// BEHAVIOUR
//  - Reset values: all outputs 0 except SIO_D_out=1; state IDLE; regfile=RESET_VAL; sub_addr=0.
//  - Input sampling:
//    - SIO_C and SIO_D_in pass through 2-flop synchronisers; edges are detected on the synced values.
//    - Rise/fall = synced(n) vs synced(n-1).
//  - START = SIO_D fall while SIO_C high; STOP = SIO_D rise while SIO_C high.
//    - Both are legal in any state.
//    - START (incl. repeated START) -> ID with bit count cleared. STOP -> IDLE.
//  - Data bits: sampled on SIO_C rise, MSB first. Target-driven bits change on SIO_C fall.
//  - States and transitions:
//    - IDLE -> ID on START.
//    - ID: shift 8 bits; then IDX (9th don't-care bit).
//      - ID[7:1] != DEVICE_ID[7:1] -> set id_err, go to WAIT_STOP; never drive SIO_D.
//    - IDX: if ID[0]=0 -> SUB; if ID[0]=1 -> RDATA, loading regfile[sub_addr] into the tx shifter.
//    - SUB: shift 8 bits into sub_addr; then SUBX -> WDATA.
//      - A STOP here ends a 2-phase write; sub_addr stays latched.
//    - WDATA: shift 8 bits; then WDATAX.
//      - On the 8th SIO_C rise: write regfile[sub_addr] and pulse wr_strobe.
//      - Update wr_addr/wr_data and post-increment sub_addr (wrap NUM_REGS-1 -> 0).
//      - Additional bytes continue auto-incrementing.
//    - RDATA: SIO_D_oe=1 for 8 bits.
//      - MSB is presented on the SIO_C fall that ends IDX; shift on each subsequent fall.
//      - On the fall after bit 0: release SIO_D (oe=0) -> RNA (master NA bit) -> WAIT_STOP.
//      - sub_addr is not incremented on reads.
//    - WAIT_STOP: ignore bits until STOP or START.
//  - Latency: wr_strobe asserts exactly 3 XCLK after the raw 8th SIO_C rise (2 sync + 1 edge/write).
//  - busy=1 in all states except IDLE.
//  - Simultaneous SIO_C and SIO_D change within one sample: SIO_C edge wins; no START/STOP is decoded.
//  - RST mid-transaction: return to IDLE and release SIO_D immediately; regfile returns to RESET_VAL.
// CONFIGURATION
//  SCCB_ACK_DRIVE_EN:
//    - Defined: target drives SIO_D=0 (oe=1) during IDX, SUBX and WDATAX (I2C-style ACK).
//      oe is asserted on the SIO_C fall entering the bit and released on the next fall.
//    - Undefined: those bits stay high-Z (pure SCCB don't-care). No other behaviour differs.
// STRUCTURE
//  - Package sccb_pkg: state enum (IDLE, ID, IDX, SUB, SUBX, WDATA, WDATAX, RDATA, RNA, WAIT_STOP)
//    and SCCB_BITS_PER_PHASE=9.
//  - Sub-module sccb_regfile: NUM_REGS x 8 synchronous-write, async-read array with reset to RESET_VAL.
//  - Synchronisers, edge/START/STOP detection and the FSM stay in sccb_target.
// TESTING
//  1. 3-phase write ID=0x42, sub=0x12, data=0xA5
//     -> one wr_strobe, wr_addr=0x12, wr_data=0xA5; regfile[0x12]=0xA5; sub_addr=0x13.
//  2. After test 1, 2-phase write sub=0x12 then 2-phase read ID=0x43
//     -> SIO_D carries 10100101 MSB first; oe=0 on the NA bit; busy drops at STOP.
//  3. Write to ID=0x60 -> id_err=1; SIO_D_oe stays 0 for the whole frame; no wr_strobe.
//  4. Write sub=0xFF with data 0x11,0x22 in one frame
//     -> regfile[0xFF]=0x11, regfile[0x00]=0x22; sub_addr=0x01.
//  5. RST asserted mid-RDATA -> next XCLK: oe=0, SIO_D_out=1, busy=0; read of 0x12 returns 0x00.
//  6. Repeated START inside SUB -> restarts at ID; following full write completes correctly;
//     with SCCB_ACK_DRIVE_EN, SIO_D=0 on each 9th bit.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM state encoding, phase length,
// and the sub-address post-increment helper.
package sccb_pkg;

  localparam int SCCB_BITS_PER_PHASE = 9;
  localparam logic [2:0] LAST_DATA_BIT = 3'(SCCB_BITS_PER_PHASE - 2);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ID        = 4'd1,
    IDX       = 4'd2,
    SUB       = 4'd3,
    SUBX      = 4'd4,
    WDATA     = 4'd5,
    WDATAX    = 4'd6,
    RDATA     = 4'd7,
    RNA       = 4'd8,
    WAIT_STOP = 4'd9
  } sccb_state_e;

  // Wraps NUM_REGS-1 back to 0.
  function automatic logic [7:0] sccb_addr_inc(input logic [7:0] a, input int n);
    return ({24'd0, a} >= 32'(n - 1)) ? 8'h00 : a + 8'd1;
  endfunction

endpackage

// File: rtl/sccb_if.sv
// SCCB pad-side signals. SIO_D is open-drain: with SIO_D_oe=0 the pad floats high
// and SIO_D_in always reflects the resolved pad level, including the target's own drive.
interface sccb_if;
  logic SIO_C;
  logic SIO_D_in;
  logic SIO_D_out;
  logic SIO_D_oe;

  modport master (output SIO_C, output SIO_D_in, input SIO_D_out, input SIO_D_oe);
  modport slave  (input SIO_C, input SIO_D_in, output SIO_D_out, output SIO_D_oe);
endinterface

// File: rtl/sccb_regfile.sv
// NUM_REGS x 8 register file: synchronous write, asynchronous read, synchronous reset
// of every entry to RESET_VAL. Addresses are reduced modulo NUM_REGS.
module sccb_regfile #(
  parameter int         NUM_REGS  = 256,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0]    mem [NUM_REGS];
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;

  assign widx  = AW'({24'd0, waddr} % NUM_REGS);
  assign ridx  = AW'({24'd0, raddr} % NUM_REGS);
  assign rdata = mem[ridx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end
endmodule

// File: rtl/sccb_target.sv
// SCCB target: oversamples SIO_C/SIO_D on XCLK, decodes 3-phase writes and 2-phase reads.
// Optional SCCB_ACK_DRIVE_EN: drive SIO_D low during the 9th bit of ID/sub-address/data phases.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = 8'h42,
  parameter int         NUM_REGS  = 256,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic        XCLK,
  input  logic        RST,
  sccb_if.slave       bus,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  sub_addr,
  output logic        busy,
  output logic        id_err,
  output sccb_state_e state_dbg
);
`ifdef SCCB_ACK_DRIVE_EN
  localparam bit ACK_DRIVE = 1'b1;
`else
  localparam bit ACK_DRIVE = 1'b0;
`endif

  logic c_s1, c_s2, c_prev, d_s1, d_s2, d_prev;
  logic c_rise, c_fall, c_high, start_det, stop_det;

  sccb_state_e state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx;
  logic [7:0]  rx_next;
  logic [6:0]  tx;
  logic        ack_rise;
  logic        rw;
  logic        rf_we;
  logic [7:0]  rf_rdata;

  // Idle bus is high, so synchronisers reset to 1 to avoid spurious edges after reset.
  always_ff @(posedge XCLK) begin
    if (RST) begin
      {c_s1, c_s2, c_prev} <= 3'b111;
      {d_s1, d_s2, d_prev} <= 3'b111;
    end else begin
      {c_s1, c_s2, c_prev} <= {bus.SIO_C, c_s1, c_s2};
      {d_s1, d_s2, d_prev} <= {bus.SIO_D_in, d_s1, d_s2};
    end
  end

  // START/STOP need SIO_C steady high across both samples, so a coincident SIO_C edge wins.
  assign c_rise    = c_s2 & ~c_prev;
  assign c_fall    = ~c_s2 & c_prev;
  assign c_high    = c_s2 & c_prev;
  assign start_det = c_high & d_prev & ~d_s2;
  assign stop_det  = c_high & ~d_prev & d_s2;
  assign rx_next   = {rx, d_s2};

  // wr_strobe is a single-cycle valid with no back-pressure; wr_addr/wr_data are stable with it.
  assign rf_we     = (state == WDATA) & c_rise & (bit_cnt == LAST_DATA_BIT) & ~start_det & ~stop_det;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  sccb_regfile #(.NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL)) u_regfile (
    .clk   (XCLK),
    .rst   (RST),
    .we    (rf_we),
    .waddr (sub_addr),
    .wdata (rx_next),
    .raddr (sub_addr),
    .rdata (rf_rdata)
  );

  always_ff @(posedge XCLK) begin
    if (RST) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx            <= 7'd0;
      tx            <= 7'd0;
      ack_rise      <= 1'b0;
      rw            <= 1'b0;
      bus.SIO_D_out <= 1'b1;
      bus.SIO_D_oe  <= 1'b0;
      wr_strobe     <= 1'b0;
      wr_addr       <= 8'h00;
      wr_data       <= 8'h00;
      sub_addr      <= 8'h00;
      id_err        <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det || stop_det) begin
        state         <= start_det ? ID : IDLE;
        bit_cnt       <= 3'd0;
        bus.SIO_D_oe  <= 1'b0;
        bus.SIO_D_out <= 1'b1;
      end else begin
        case (state)
          IDLE, WAIT_STOP: ;
          ID, SUB, WDATA: begin
            if (c_rise) begin
              rx      <= rx_next[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_DATA_BIT) begin
                ack_rise <= 1'b0;
                if (state == ID) begin
                  if (rx_next[7:1] != DEVICE_ID[7:1]) begin
                    id_err <= 1'b1;
                    state  <= WAIT_STOP;
                  end else begin
                    rw    <= rx_next[0];
                    state <= IDX;
                  end
                end else if (state == SUB) begin
                  sub_addr <= rx_next;
                  state    <= SUBX;
                end else begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= sub_addr;
                  wr_data   <= rx_next;
                  sub_addr  <= sccb_addr_inc(sub_addr, NUM_REGS);
                  state     <= WDATAX;
                end
              end
            end
          end
          // 9th bit: the first fall opens the bit, the fall after its rise closes it.
          IDX, SUBX, WDATAX: begin
            if (c_rise) begin
              ack_rise <= 1'b1;
            end else if (c_fall) begin
              if (!ack_rise) begin
                if (ACK_DRIVE) begin
                  bus.SIO_D_oe  <= 1'b1;
                  bus.SIO_D_out <= 1'b0;
                end
              end else begin
                bit_cnt       <= 3'd0;
                bus.SIO_D_oe  <= 1'b0;
                bus.SIO_D_out <= 1'b1;
                if (state == IDX && rw) begin
                  tx            <= rf_rdata[6:0];
                  bus.SIO_D_oe  <= 1'b1;
                  bus.SIO_D_out <= rf_rdata[7];
                  state         <= RDATA;
                end else if (state == IDX) begin
                  state <= SUB;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (c_fall) begin
              if (bit_cnt == LAST_DATA_BIT) begin
                bus.SIO_D_oe  <= 1'b0;
                bus.SIO_D_out <= 1'b1;
                state         <= RNA;
              end else begin
                bus.SIO_D_out <= tx[6];
                tx            <= {tx[5:0], 1'b0};
                bit_cnt       <= bit_cnt + 3'd1;
              end
            end
          end
          RNA: if (c_rise) state <= WAIT_STOP;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
